// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the LCD sequencer: FSM state encoding,
//               HD44780 command bytes, table lengths and the init-table ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_XFER_WAIT = 3'd2,
        ST_DELAY     = 3'd3,
        ST_IDLE      = 3'd4
    } state_t;

    // Which post-command wait an init entry needs; resolved to a cycle count
    // in the sequencer where the timing parameters live.
    typedef enum logic [1:0] {
        DLY_NONE  = 2'd0,
        DLY_5MS   = 2'd1,
        DLY_100US = 2'd2,
        DLY_CLEAR = 2'd3
    } dly_sel_t;

    typedef struct packed {
        logic [7:0] cmd;
        dly_sel_t   dly;
    } init_entry_t;

    localparam logic [7:0] c_CMD_WAKE    = 8'h30;
    localparam logic [7:0] c_CMD_4BIT    = 8'h20;
    localparam logic [7:0] c_CMD_FUNC    = 8'h28;
    localparam logic [7:0] c_CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] c_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] c_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] c_CMD_LINE1   = 8'h80;
    localparam logic [7:0] c_CMD_LINE2   = 8'hC0;
    localparam logic [7:0] c_BLANK       = 8'h20;

    localparam int c_INIT_LEN    = 8;
    localparam int c_REFRESH_LEN = 34;

    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        e = '{cmd: c_CMD_ENTRY, dly: DLY_NONE};
        case (idx)
            3'd0: e = '{cmd: c_CMD_WAKE,    dly: DLY_5MS};
            3'd1: e = '{cmd: c_CMD_WAKE,    dly: DLY_100US};
            3'd2: e = '{cmd: c_CMD_WAKE,    dly: DLY_100US};
            3'd3: e = '{cmd: c_CMD_4BIT,    dly: DLY_NONE};
            3'd4: e = '{cmd: c_CMD_FUNC,    dly: DLY_NONE};
            3'd5: e = '{cmd: c_CMD_DISP_ON, dly: DLY_NONE};
            3'd6: e = '{cmd: c_CMD_CLEAR,   dly: DLY_CLEAR};
            3'd7: e = '{cmd: c_CMD_ENTRY,   dly: DLY_NONE};
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sequencer_if
// Description : Frame-buffer write port, refresh request and LCD byte-transfer
//               handshake of the LCD sequencer.
//               slave  : sequencer side (drives ready, lcd_start/rs/data)
//               master : host/nibble-stage side (drives writes, refresh, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_sequencer_if;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh;
    logic       ready;
    logic       lcd_start;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       lcd_busy;

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh, lcd_busy,
        output ready, lcd_start, lcd_rs, lcd_data
    );

    modport master (
        output wr_en, wr_addr, wr_data, refresh, lcd_busy,
        input  ready, lcd_start, lcd_rs, lcd_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : lcd_frame_buf
// Description : 32 x 8 character buffer (two 16-character lines).
//               clk/rst    : clock, synchronous reset (fills with spaces)
//               i_wr_*     : write port, visible from the next cycle
//               i_rd_addr  : asynchronous read address, o_rd_data its byte
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_buf
    import lcd_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_wr_en,
    input  wire logic [4:0] i_wr_addr,
    input  wire logic [7:0] i_wr_data,
    input  wire logic [4:0] i_rd_addr,
    output logic      [7:0] o_rd_data
);

    logic [7:0] r_mem [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= c_BLANK;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_sequencer
// Description : Runs the HD44780 power-up/init sequence, then copies the
//               32-character frame buffer to the display on each refresh.
//               clk, rst : 12 MHz clock, synchronous active-high reset
//               bus      : lcd_sequencer_if.slave - buffer writes, refresh,
//                          ready, and lcd_start/rs/data/busy transfer strobe
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP  = 480000,
    parameter int T_5MS    = 60000,
    parameter int T_100US  = 1200,
    parameter int T_CLEAR  = 24000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    lcd_sequencer_if.slave  bus
);

    localparam logic [18:0] c_PWRUP_CYC = 19'(T_PWRUP);
    localparam logic [18:0] c_5MS_CYC   = 19'(T_5MS);
    localparam logic [18:0] c_100US_CYC = 19'(T_100US);
    localparam logic [18:0] c_CLEAR_CYC = 19'(T_CLEAR);

    function automatic logic [18:0] delay_len(input dly_sel_t sel);
        case (sel)
            DLY_5MS:   return c_5MS_CYC;
            DLY_100US: return c_100US_CYC;
            DLY_CLEAR: return c_CLEAR_CYC;
            default:   return 19'd0;
        endcase
    endfunction

    state_t      r_state, w_state_nxt;
    logic [18:0] r_cnt, w_cnt_nxt;
    logic [5:0]  r_idx, w_idx_nxt;
    logic        r_refresh_mode, w_refresh_mode_nxt;
    logic        r_pending, w_pending_nxt;
    logic        r_start, w_start_nxt;
    logic        r_rs, w_rs_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic [4:0]  r_rd_addr, w_rd_addr_nxt;
    logic        r_hold, w_hold_nxt;

    init_entry_t w_entry;
    logic [18:0] w_dly_len;
    logic [18:0] w_post_dly;
    logic        w_last;
    state_t      w_adv_state;
    logic [5:0]  w_adv_idx;
    logic [7:0]  w_rd_data;

    lcd_frame_buf u_frame_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_entry    = init_rom(r_idx[2:0]);
    assign w_dly_len  = delay_len(w_entry.dly);
    assign w_post_dly = r_refresh_mode ? 19'd0 : w_dly_len;
    assign w_last     = r_refresh_mode ? (r_idx == 6'(c_REFRESH_LEN - 1))
                                       : (r_idx == 6'(c_INIT_LEN - 1));
    assign w_adv_state = w_last ? ST_IDLE : ST_ISSUE;
    assign w_adv_idx   = w_last ? 6'd0 : r_idx + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_PWR_WAIT;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_refresh_mode <= 1'b0;
            r_pending      <= 1'b0;
            r_start        <= 1'b0;
            r_rs           <= 1'b0;
            r_cmd          <= '0;
            r_rd_addr      <= '0;
            r_hold         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_refresh_mode <= w_refresh_mode_nxt;
            r_pending      <= w_pending_nxt;
            r_start        <= w_start_nxt;
            r_rs           <= w_rs_nxt;
            r_cmd          <= w_cmd_nxt;
            r_rd_addr      <= w_rd_addr_nxt;
            r_hold         <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_idx_nxt          = r_idx;
        w_refresh_mode_nxt = r_refresh_mode;
        // A new request always wins over clearing, so a refresh arriving at
        // pass start or pass end still buys one more pass.
        w_pending_nxt      = r_pending | bus.refresh;
        w_start_nxt        = 1'b0;
        w_rs_nxt           = 1'b0;
        w_cmd_nxt          = r_cmd;
        w_rd_addr_nxt      = r_rd_addr;
        w_hold_nxt         = r_hold;

        case (r_state)
            ST_PWR_WAIT: begin
                if (c_PWRUP_CYC == 19'd0 || r_cnt == c_PWRUP_CYC - 19'd1) begin
                    w_state_nxt        = ST_ISSUE;
                    w_cnt_nxt          = '0;
                    w_idx_nxt          = '0;
                    w_refresh_mode_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 19'd1;
                end
            end

            ST_ISSUE: begin
                if (!bus.lcd_busy) begin
                    w_start_nxt = 1'b1;
                    w_hold_nxt  = 1'b1;
                    w_state_nxt = ST_XFER_WAIT;
                    if (!r_refresh_mode) begin
                        w_cmd_nxt = w_entry.cmd;
                    end else if (r_idx == 6'd0) begin
                        w_cmd_nxt = c_CMD_LINE1;
                    end else if (r_idx == 6'd17) begin
                        w_cmd_nxt = c_CMD_LINE2;
                    end else begin
                        // Character slots: 1-16 map to buf 0-15, 18-33 to
                        // buf 16-31; the 5-bit wrap makes 32/33 land on 30/31.
                        w_rs_nxt      = 1'b1;
                        w_rd_addr_nxt = r_idx[4:0] - ((r_idx < 6'd17) ? 5'd1 : 5'd2);
                    end
                end
            end

            ST_XFER_WAIT: begin
                // Busy is not trusted in the strobe cycle nor the one after
                // it, since the nibble stage may take a cycle to raise it.
                if (r_start) begin
                    w_hold_nxt = 1'b1;
                end else if (r_hold) begin
                    w_hold_nxt = 1'b0;
                end else if (!bus.lcd_busy) begin
                    if (w_post_dly != 19'd0) begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = w_adv_state;
                        w_idx_nxt   = w_adv_idx;
                    end
                end
            end

            ST_DELAY: begin
                if (r_cnt == w_dly_len - 19'd1) begin
                    w_state_nxt = w_adv_state;
                    w_idx_nxt   = w_adv_idx;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 19'd1;
                end
            end

            ST_IDLE: begin
                if (r_pending) begin
                    w_pending_nxt      = bus.refresh;
                    w_state_nxt        = ST_ISSUE;
                    w_idx_nxt          = '0;
                    w_refresh_mode_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_PWR_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Character bytes are fetched combinationally during the strobe cycle so
    // late writes to a not-yet-sent address still make it out.
    assign bus.ready     = (r_state == ST_IDLE) && !r_pending;
    assign bus.lcd_start = r_start;
    assign bus.lcd_rs    = r_rs;
    assign bus.lcd_data  = r_start ? (r_rs ? w_rd_data : r_cmd) : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_sequencer
// Description : Self-checking bench for lcd_sequencer with a 20-cycle busy
//               LCD stub and a strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_sequencer_if bus_if ();

    lcd_sequencer #(
        .T_PWRUP (100),
        .T_5MS   (50),
        .T_100US (10),
        .T_CLEAR (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         busy_cnt = 0;
    int         strobe_cyc [$];
    logic [8:0] exp_q [$];
    logic [8:0] exp_v;
    logic [7:0] model_buf [32];

    always @(posedge clk) cyc <= cyc + 1;

    // LCD nibble-stage stub: busy for 20 cycles after each accepted strobe.
    always @(posedge clk) begin
        if (bus_if.lcd_start && busy_cnt == 0) busy_cnt <= 20;
        else if (busy_cnt > 0)                 busy_cnt <= busy_cnt - 1;
    end
    assign bus_if.lcd_busy = (busy_cnt != 0);

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus_if.lcd_start === 1'b1) begin
            strobe_cyc.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe[%0d]: got rs=%0b data=%02h, required no strobe",
                         strobe_cyc.size() - 1, bus_if.lcd_rs, bus_if.lcd_data);
            end else begin
                exp_v = exp_q.pop_front();
                if ({bus_if.lcd_rs, bus_if.lcd_data} !== exp_v) begin
                    n_err++;
                    $display("FAIL strobe[%0d]: got rs=%0b data=%02h, required rs=%0b data=%02h",
                             strobe_cyc.size() - 1, bus_if.lcd_rs, bus_if.lcd_data,
                             exp_v[8], exp_v[7:0]);
                end
            end
            n_cmp++;
            if (bus_if.lcd_busy !== 1'b0) begin
                n_err++;
                $display("FAIL strobe_while_busy: got busy=%0b, required 0", bus_if.lcd_busy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        model_buf[a]   = d;
        tick(1);
        bus_if.wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        bus_if.refresh = 1'b1;
        tick(1);
        bus_if.refresh = 1'b0;
    endtask

    task automatic push_init();
        logic [7:0] seq [8];
        seq = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, seq[i]});
    endtask

    task automatic push_pass();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, model_buf[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, model_buf[i]});
    endtask

    task automatic wait_strobes(input string name, input int n, input int limit);
        int k;
        k = 0;
        while (strobe_cyc.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_seen"}, 32'(strobe_cyc.size() >= n), 1);
    endtask

    // Waits for ready with the scoreboard drained; ready while strobes are
    // still owed counts as a failure.
    task automatic wait_idle(input string name, input int limit);
        int k;
        bit early;
        bit done;
        k = 0; early = 0; done = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
            if (bus_if.ready === 1'b1) begin
                if (exp_q.size() != 0) early = 1;
                else                   done  = 1;
            end
        end
        chk({name, "_ready"}, 32'(done), 1);
        chk({name, "_ready_early"}, 32'(early), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"},     32'(bus_if.ready),     0);
        chk({name, "_lcd_start"}, 32'(bus_if.lcd_start), 0);
        chk({name, "_lcd_rs"},    32'(bus_if.lcd_rs),    0);
        chk({name, "_lcd_data"},  32'(bus_if.lcd_data),  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;
        int rel_idx;
        int base;
        int k;

        rst            = 1'b1;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = '0;
        bus_if.wr_data = '0;
        bus_if.refresh = 1'b0;
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;

        // ---- Power-up, init, refresh requested during PWR_WAIT ----
        tick(3);
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst     = 1'b0;
        rel_cyc = cyc;
        rel_idx = strobe_cyc.size();
        push_init();
        push_pass();
        tick(10);
        pulse_refresh();
        wait_strobes("init", rel_idx + 9, 2000);
        if (strobe_cyc.size() >= rel_idx + 9) begin
            // PWR_WAIT 100 cycles, ISSUE, then the registered strobe.
            chk("pwrup_latency", 32'(strobe_cyc[rel_idx] - rel_cyc), 101);
            // 20 busy + 1 completion + 50 delay cycles before the next ISSUE.
            chk("wake_gap_ge71",
                32'((strobe_cyc[rel_idx + 1] - strobe_cyc[rel_idx]) >= 71), 1);
            // 0x06 at S: idle stub at S+21, IDLE S+22, ISSUE S+23, strobe S+24.
            chk("pass_after_init",
                32'(strobe_cyc[rel_idx + 8] - strobe_cyc[rel_idx + 7]), 24);
        end
        wait_idle("init_pass", 3000);

        // ---- "Hello" on line 1 ----
        wr(5'd0, "H"); wr(5'd1, "e"); wr(5'd2, "l"); wr(5'd3, "l"); wr(5'd4, "o");
        base = strobe_cyc.size();
        push_pass();
        pulse_refresh();
        wait_idle("hello", 2000);
        chk("hello_count", 32'(strobe_cyc.size() - base), 34);

        // ---- Three refreshes mid-pass, late write to addr 31 ----
        base = strobe_cyc.size();
        model_buf[31] = "Z";
        push_pass();
        push_pass();
        pulse_refresh();
        wait_strobes("mid", base + 3, 500);
        wr(5'd31, "Z");
        pulse_refresh();
        tick(7);
        pulse_refresh();
        tick(40);
        pulse_refresh();
        wait_idle("multi", 4000);
        tick(100);
        chk("multi_count", 32'(strobe_cyc.size() - base), 68);

        // ---- Reset in the middle of a pass while the stub is busy ----
        base = strobe_cyc.size();
        push_pass();
        pulse_refresh();
        wait_strobes("pre_rst", base + 10, 1000);
        k = 0;
        while (!(bus_if.lcd_busy === 1'b1 && bus_if.lcd_start === 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_busy_seen", 32'(bus_if.lcd_busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst     = 1'b0;
        rel_cyc = cyc;
        rel_idx = strobe_cyc.size();
        push_init();
        push_pass();
        tick(5);
        pulse_refresh();
        wait_strobes("reinit", rel_idx + 1, 500);
        if (strobe_cyc.size() >= rel_idx + 1)
            chk("re_pwrup_latency", 32'(strobe_cyc[rel_idx] - rel_cyc), 101);
        wait_idle("reinit_pass", 3000);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter T_PWRUP, default 480000, power-on wait in clk cycles (40 ms at 12 MHz).
REQ-002 SHALL have parameter T_5MS, default 60000, wait after first 0x30 in clk cycles.
REQ-003 SHALL have parameter T_100US, default 1200, wait after second and third 0x30 in clk cycles.
REQ-004 SHALL have parameter T_CLEAR, default 24000, wait after 0x01 in clk cycles (2 ms).
REQ-005 clk  input  1  system clock, 12 MHz; one clock domain, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_en  input  1  frame-buffer write strobe.
REQ-008 wr_addr  input  5  buffer address; 0-15 = line 1, 16-31 = line 2.
REQ-009 wr_data  input  8  ASCII character to store.
REQ-010 refresh  input  1  one-cycle request to copy the buffer to the display.
REQ-011 ready  output  1  init done, no refresh in progress or pending.
REQ-012 lcd_start  output  1  one-cycle transfer strobe to the lcd nibble stage.
REQ-013 lcd_rs  output  1  0 = command, 1 = character; valid while lcd_start=1.
REQ-014 lcd_data  output  8  byte to transfer; valid while lcd_start=1.
REQ-015 lcd_busy  input  1  lcd nibble stage busy; high within 1 cycle after lcd_start.

Function
REQ-016 States SHALL be PWR_WAIT, ISSUE, XFER_WAIT, DELAY, IDLE.
REQ-017 After reset, SHALL stay in PWR_WAIT for exactly T_PWRUP cycles, then enter ISSUE with init index 0.
REQ-018 Init table (rs=0, post-delay): 0x30/T_5MS, 0x30/T_100US, 0x30/T_100US, 0x20/0, 0x28/0, 0x0C/0, 0x01/T_CLEAR, 0x06/0.
REQ-019 ISSUE SHALL assert lcd_start for exactly one cycle, only when lcd_busy=0; otherwise it holds without a strobe.
REQ-020 XFER_WAIT SHALL ignore lcd_busy in the cycle after lcd_start, then wait for lcd_busy=0.
REQ-021 On transfer completion, a nonzero post-delay SHALL enter DELAY for exactly that many cycles. A zero post-delay SHALL go directly to the next ISSUE.
REQ-022 After the 8th init entry completes, SHALL enter IDLE.
REQ-023 Refresh pass SHALL be 34 transfers, index 0-33:
  - 0: cmd 0x80
  - 1-16: chars buf[0..15]
  - 17: cmd 0xC0
  - 18-33: chars buf[16..31]
  - no post-delays
REQ-024 Each character byte SHALL be read from the buffer in the cycle lcd_start is asserted. Writes landing mid-pass appear if their address has not yet been sent.
REQ-025 refresh SHALL set a pending flag in any state, including PWR_WAIT and during a pass.
REQ-026 IDLE with pending=1 SHALL clear pending and start a pass the next cycle. Multiple requests during one pass collapse to one further pass.
REQ-027 Simultaneous refresh and pass completion SHALL leave pending=1 and start another pass.
REQ-028 Buffer writes SHALL be accepted every cycle in every state, taking effect the next cycle.
REQ-029 ready SHALL be 1 only in IDLE with pending=0.
REQ-030 Delay counter SHALL be 19 bits. A zero-valued delay parameter SHALL be treated as no delay.

Reset
REQ-031 rst SHALL, on any state including mid-transfer, return to PWR_WAIT with counter and indices cleared and pending=0.
REQ-032 rst SHALL fill all buffer entries with 0x20.
REQ-033 Reset output values SHALL be ready=0, lcd_start=0, lcd_rs=0, lcd_data=0x00.

Structure
REQ-034 Shared package lcd_pkg SHALL hold:
  - state encoding
  - command constants 0x30/0x20/0x28/0x0C/0x01/0x06/0x80/0xC0
  - init table length 8 and refresh length 34
REQ-035 Init table SHALL be a combinational ROM function of index, returning {cmd, delay-select}.
REQ-036 Sub-module lcd_frame_buf SHALL hold the 32x8 buffer with one write port and one async read port.

Verification
REQ-037 Bench SHALL use T_PWRUP=100, T_5MS=50, T_100US=10, T_CLEAR=30 and a behavioural lcd stub with busy for 20 cycles per transfer.
REQ-038 Reset release -> first lcd_start exactly 101 cycles later, rs=0, data 0x30. Next strobes: 0x30 after ≥50 idle cycles, then 0x30, 0x20, 0x28, 0x0C, 0x01, 0x06. ready=1 after 0x06 completes.
REQ-039 Write "Hello" at addr 0-4, pulse refresh -> 34 strobes: 0x80, 'H','e','l','l','o', eleven 0x20, 0xC0, sixteen 0x20. ready returns to 1.
REQ-040 Pulse refresh during PWR_WAIT -> no strobe before init ends. A pass starts immediately after 0x06, with ready=0 throughout.
REQ-041 Three refresh pulses mid-pass -> exactly one further 34-strobe pass. wr_addr=31 written during pass 1 before index 33 -> new value appears at index 33.
REQ-042 Assert rst during a refresh pass with lcd_busy=1 -> outputs at reset values next cycle. Buffer reads 0x20. Init restarts with 0x30 after T_PWRUP.
